dmio_arbiter: RTL and testbench

- Shares the single data-memory/IO block (4096 x 64-bit RAM; address bit 12 selects the switch/LED register) between two requesters.
- Port 0 is the CPU load/store unit. Port 1 is the debug/program loader (UART loader, test DMA).
- Sits between both requesters and the memory block. It arbitrates, registers the winning command, drives the memory's address/write-data/write-enable inputs, and returns registered read data to the winner.

---
 rtl/dmio_arbiter_if.sv | 43 ++++
 rtl/dmio_arbiter.sv | 107 ++++++++++
 tb/tb_dmio_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmio_arbiter_if.sv
// Two-requester bus into the data-memory/IO arbiter
// plus the arbiter's side of the memory block.
interface dmio_arbiter_if;
  logic        req0;
  logic        we0;
  logic [63:0] addr0;
  logic [63:0] wdata0;
  logic        gnt0;
  logic        rvalid0;
  logic [63:0] rdata0;
  logic        req1;
  logic        we1;
  logic [63:0] addr1;
  logic [63:0] wdata1;
  logic        gnt1;
  logic        rvalid1;
  logic [63:0] rdata1;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_wr;
  logic [63:0] mem_rdata;
  logic        busy;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  mem_rdata,
    output gnt0, rvalid0, rdata0,
    output gnt1, rvalid1, rdata1,
    output mem_addr, mem_wdata, mem_wr,
    output busy
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output mem_rdata,
    input  gnt0, rvalid0, rdata0,
    input  gnt1, rvalid1, rdata1,
    input  mem_addr, mem_wdata, mem_wr,
    input  busy
  );
endinterface

// File: rtl/dmio_arbiter.sv
// Two-port arbiter for the shared data-memory/IO block:
// CPU LSU on port 0, debug/program loader on port 1.
module dmio_arbiter #(
  parameter bit FIXED_PRIO   = 1'b0,
  parameter bit LOADER_IO_EN = 1'b1
) (
  input logic           clk,
  input logic           rst_n,
  dmio_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  state_e      state_q, state_d;
  logic        last_q, last_d;
  logic        port_q, port_d;
  logic        we_q, we_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] rdata0_q, rdata0_d;
  logic [63:0] rdata1_q, rdata1_d;
  logic        win;
  logic        io_block;

  // port 1 wins when alone, or on a round-robin tie after port 0
  assign win = (bus.req1 && !bus.req0)
            || (bus.req1 && bus.req0
                && !FIXED_PRIO && !last_q);

  assign io_block = port_q && !LOADER_IO_EN
                 && addr_q[12];

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    port_d   = port_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          state_d = ACCESS;
          last_d  = win;
          port_d  = win;
          we_d    = win ? bus.we1 : bus.we0;
          addr_d  = win ? bus.addr1 : bus.addr0;
          wdata_d = win ? bus.wdata1 : bus.wdata0;
        end
      end
      ACCESS: begin
        state_d = RESP;
        if (!we_q && port_q)
          rdata1_d = bus.mem_rdata;
        if (!we_q && !port_q)
          rdata0_d = bus.mem_rdata;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      port_q   <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      port_q   <= port_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // rst_n gate keeps a reset during ACCESS from landing the write
  assign bus.mem_wr = rst_n && (state_q == ACCESS)
                   && we_q && !io_block;

  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.gnt0      = (state_q == ACCESS) && !port_q;
  assign bus.gnt1      = (state_q == ACCESS) && port_q;
  assign bus.rvalid0   = (state_q == RESP) && !we_q
                      && !port_q;
  assign bus.rvalid1   = (state_q == RESP) && !we_q
                      && port_q;
  assign bus.rdata0    = rdata0_q;
  assign bus.rdata1    = rdata1_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_dmio_arbiter.sv
// Bench for dmio_arbiter: two instances (round-robin/IO-blocked
// and fixed-priority/IO-open) checked against a timeline model.
module tb_dmio_arbiter;

  localparam logic [63:0] SW = 64'h3C;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, we0, req1, we1;
  logic [63:0] addr0, wdata0, addr1, wdata1;

  always #5 clk = ~clk;

  dmio_arbiter_if ifa ();
  dmio_arbiter_if ifb ();

  assign ifa.req0 = req0;    assign ifb.req0 = req0;
  assign ifa.we0 = we0;      assign ifb.we0 = we0;
  assign ifa.addr0 = addr0;  assign ifb.addr0 = addr0;
  assign ifa.wdata0 = wdata0; assign ifb.wdata0 = wdata0;
  assign ifa.req1 = req1;    assign ifb.req1 = req1;
  assign ifa.we1 = we1;      assign ifb.we1 = we1;
  assign ifa.addr1 = addr1;  assign ifb.addr1 = addr1;
  assign ifa.wdata1 = wdata1; assign ifb.wdata1 = wdata1;

  logic [63:0] ram [2][4096];
  logic [63:0] led [2];

  assign ifa.mem_rdata = ifa.mem_addr[12] ? SW
                       : ram[0][ifa.mem_addr[11:0]];
  assign ifb.mem_rdata = ifb.mem_addr[12] ? SW
                       : ram[1][ifb.mem_addr[11:0]];

  dmio_arbiter #(.FIXED_PRIO(1'b0), .LOADER_IO_EN(1'b0))
    u_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  dmio_arbiter #(.FIXED_PRIO(1'b1), .LOADER_IO_EN(1'b1))
    u_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  logic [1:0]  o_gnt0, o_gnt1, o_rv0, o_rv1, o_wr, o_busy;
  logic [63:0] o_addr [2];
  logic [63:0] o_wd [2];
  logic [63:0] o_rd0 [2];
  logic [63:0] o_rd1 [2];

  assign o_gnt0 = {ifb.gnt0, ifa.gnt0};
  assign o_gnt1 = {ifb.gnt1, ifa.gnt1};
  assign o_rv0  = {ifb.rvalid0, ifa.rvalid0};
  assign o_rv1  = {ifb.rvalid1, ifa.rvalid1};
  assign o_wr   = {ifb.mem_wr, ifa.mem_wr};
  assign o_busy = {ifb.busy, ifa.busy};
  assign o_addr[0] = ifa.mem_addr;  assign o_addr[1] = ifb.mem_addr;
  assign o_wd[0] = ifa.mem_wdata;   assign o_wd[1] = ifb.mem_wdata;
  assign o_rd0[0] = ifa.rdata0;     assign o_rd0[1] = ifb.rdata0;
  assign o_rd1[0] = ifa.rdata1;     assign o_rd1[1] = ifb.rdata1;

  int errors = 0;
  int checks = 0;

  task automatic chk1(input string nm, input logic act,
                      input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk64(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Model: a transaction accepted at cycle t0 is granted in t0+1,
  // responds in t0+2 and frees the port for sampling at t0+3.
  int          cyc = 0;
  int          t0 [2];
  logic        last_m [2];
  logic        port_m [2];
  logic        we_m [2];
  logic [63:0] addr_m [2];
  logic [63:0] wd_m [2];
  logic [63:0] erd0 [2];
  logic [63:0] erd1 [2];
  logic [63:0] eled [2];
  logic [63:0] eram [2][4096];
  bit          init_done = 1'b0;
  bit          started = 1'b0;

  function automatic logic [63:0] init_val(int i);
    return 64'hC0DE_0000_0000_0000 | 64'(i);
  endfunction

  function automatic bit fixed_prio(int k);
    return k == 1;
  endfunction

  function automatic bit io_open(int k);
    return k == 1;
  endfunction

  function automatic int age(int k);
    return cyc - t0[k];
  endfunction

  function automatic logic winner(int k);
    if (req0 && req1)
      return fixed_prio(k) ? 1'b0 : !last_m[k];
    return req1;
  endfunction

  function automatic bit blocked(int k);
    return port_m[k] && !io_open(k) && addr_m[k][12];
  endfunction

  function automatic logic [63:0] rd_val(int k);
    return addr_m[k][12] ? SW : eram[k][addr_m[k][11:0]];
  endfunction

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 4096; i++)
        for (int k = 0; k < 2; k++) begin
          ram[k][i]  <= init_val(i);
          eram[k][i] <= init_val(i);
        end
      for (int k = 0; k < 2; k++) begin
        led[k]  <= '0;
        eled[k] <= '0;
      end
      init_done <= 1'b1;
    end
    for (int k = 0; k < 2; k++) begin
      if (o_wr[k]) begin
        if (o_addr[k][12]) led[k] <= o_wd[k];
        else ram[k][o_addr[k][11:0]] <= o_wd[k];
      end
      if (!rst_n) begin
        t0[k]     <= cyc - 100;
        last_m[k] <= 1'b1;
        addr_m[k] <= '0;
        wd_m[k]   <= '0;
        erd0[k]   <= '0;
        erd1[k]   <= '0;
      end else begin
        if (age(k) == 1 && we_m[k] && !blocked(k)) begin
          if (addr_m[k][12]) eled[k] <= wd_m[k];
          else eram[k][addr_m[k][11:0]] <= wd_m[k];
        end
        if (age(k) == 1 && !we_m[k]) begin
          if (port_m[k]) erd1[k] <= rd_val(k);
          else erd0[k] <= rd_val(k);
        end
        if (age(k) >= 3 && (req0 || req1)) begin
          t0[k]     <= cyc;
          port_m[k] <= winner(k);
          last_m[k] <= winner(k);
          we_m[k]   <= winner(k) ? we1 : we0;
          addr_m[k] <= winner(k) ? addr1 : addr0;
          wd_m[k]   <= winner(k) ? wdata1 : wdata0;
        end
      end
    end
    cyc     <= cyc + 1;
    started <= 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        chk1($sformatf("busy[%0d]", k), o_busy[k],
             age(k) == 1 || age(k) == 2);
        chk1($sformatf("gnt0[%0d]", k), o_gnt0[k],
             age(k) == 1 && !port_m[k]);
        chk1($sformatf("gnt1[%0d]", k), o_gnt1[k],
             age(k) == 1 && port_m[k]);
        chk1($sformatf("rvalid0[%0d]", k), o_rv0[k],
             age(k) == 2 && !we_m[k] && !port_m[k]);
        chk1($sformatf("rvalid1[%0d]", k), o_rv1[k],
             age(k) == 2 && !we_m[k] && port_m[k]);
        chk1($sformatf("mem_wr[%0d]", k), o_wr[k],
             rst_n && age(k) == 1 && we_m[k] && !blocked(k));
        chk64($sformatf("mem_addr[%0d]", k), o_addr[k], addr_m[k]);
        chk64($sformatf("mem_wdata[%0d]", k), o_wd[k], wd_m[k]);
        chk64($sformatf("rdata0[%0d]", k), o_rd0[k], erd0[k]);
        chk64($sformatf("rdata1[%0d]", k), o_rd1[k], erd1[k]);
        chk64($sformatf("led[%0d]", k), led[k], eled[k]);
      end
    end
  end

  int          g_lat;
  logic        g_wr, rv_seen;
  logic [63:0] g_addr, rv_data;

  // One request on instance a's timing; drops req after gnt.
  task automatic txn(input logic p, input logic we,
                     input logic [63:0] a, input logic [63:0] d);
    bit seen;
    seen = 1'b0;
    g_lat = 0;
    @(posedge clk); #1;
    if (p) begin
      req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d;
    end else begin
      req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d;
    end
    for (int n = 1; n <= 20 && !seen; n++) begin
      @(negedge clk);
      if (p ? o_gnt1[0] : o_gnt0[0]) begin
        seen   = 1'b1;
        g_lat  = n;
        g_wr   = o_wr[0];
        g_addr = o_addr[0];
      end
    end
    chk1("txn_gnt_seen", seen, 1'b1);
    @(posedge clk); #1;
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk);
    rv_seen = p ? o_rv1[0] : o_rv0[0];
    rv_data = p ? o_rd1[0] : o_rd0[0];
    @(posedge clk);
  endtask

  int ga[$];
  int gidx[$];
  int gb0, gb1;
  bit seen_r;

  initial begin
    rst_n = 1'b0;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;

    // request held through reset
    req0 = 1'b1; addr0 = 64'h8;
    repeat (2) begin
      @(negedge clk);
      chk1("reset_no_gnt0", o_gnt0[0], 1'b0);
      chk64("reset_mem_addr", o_addr[0], 64'h0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    g_lat = 0;
    for (int n = 1; n <= 10 && g_lat == 0; n++) begin
      @(negedge clk);
      if (o_gnt0[0]) g_lat = n;
    end
    chk64("reset_release_gnt_lat", 64'(g_lat), 64'd2);
    @(posedge clk); #1;
    req0 = 1'b0;
    repeat (2) @(posedge clk);
    chk64("reset_first_read", o_rd0[0], init_val(8));

    // port 0 write then read
    txn(1'b0, 1'b1, 64'h10, 64'hDEADBEEF_01234567);
    chk1("wr0_mem_wr", g_wr, 1'b1);
    chk64("wr0_mem_addr", g_addr, 64'h10);
    chk1("wr0_no_rvalid", rv_seen, 1'b0);
    txn(1'b0, 1'b0, 64'h10, 64'h0);
    chk64("rd0_gnt_lat", 64'(g_lat), 64'd2);
    chk1("rd0_rvalid", rv_seen, 1'b1);
    chk64("rd0_rdata", rv_data, 64'hDEADBEEF_01234567);

    // loader IO write: blocked on a, allowed on b
    txn(1'b1, 1'b1, 64'h1000, 64'hA5);
    chk1("io1_mem_wr_blocked", g_wr, 1'b0);
    chk64("io1_led_a", led[0], 64'h0);
    chk64("io1_led_b", led[1], 64'hA5);
    txn(1'b0, 1'b1, 64'h1000, 64'hA5);
    chk1("io0_mem_wr", g_wr, 1'b1);
    chk64("io0_led_a", led[0], 64'hA5);

    // switch read through port 1
    txn(1'b1, 1'b0, 64'h1000, 64'h0);
    chk1("sw_rvalid1", rv_seen, 1'b1);
    chk64("sw_rdata1", rv_data, 64'h3C);

    // contention, both held; last is 1 on both instances
    @(posedge clk); #1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 64'h40;
    req1 = 1'b1; we1 = 1'b0; addr1 = 64'h48;
    gb0 = 0; gb1 = 0;
    for (int n = 1; n <= 13; n++) begin
      @(negedge clk);
      if (o_gnt0[0]) begin ga.push_back(0); gidx.push_back(n); end
      if (o_gnt1[0]) begin ga.push_back(1); gidx.push_back(n); end
      if (o_gnt0[1]) gb0++;
      if (o_gnt1[1]) gb1++;
    end
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
    repeat (4) @(posedge clk);
    chk64("rr_grant_count", 64'(ga.size()), 64'd4);
    if (ga.size() == 4) begin
      chk64("rr_seq0", 64'(ga[0]), 64'd0);
      chk64("rr_seq1", 64'(ga[1]), 64'd1);
      chk64("rr_seq2", 64'(ga[2]), 64'd0);
      chk64("rr_seq3", 64'(ga[3]), 64'd1);
      chk64("rr_spacing", 64'(gidx[1] - gidx[0]), 64'd3);
    end
    chk64("fp_gnt0_count", 64'(gb0), 64'd4);
    chk64("fp_gnt1_count", 64'(gb1), 64'd0);

    // reset while a write to 0x20 is in ACCESS
    @(posedge clk); #1;
    req0 = 1'b1; we0 = 1'b1; addr0 = 64'h20;
    wdata0 = 64'h1234_5678_9ABC_DEF0;
    seen_r = 1'b0;
    for (int n = 1; n <= 20 && !seen_r; n++) begin
      @(negedge clk);
      if (o_gnt0[0]) seen_r = 1'b1;
    end
    chk1("midrst_gnt_seen", seen_r, 1'b1);
    #1;
    rst_n = 1'b0;
    req0 = 1'b0; we0 = 1'b0;
    @(negedge clk);
    chk1("midrst_no_rvalid", o_rv0[0], 1'b0);
    chk1("midrst_idle", o_busy[0], 1'b0);
    chk1("midrst_no_wr", o_wr[0], 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk);
    txn(1'b0, 1'b0, 64'h20, 64'h0);
    chk1("midrst_read_rvalid", rv_seen, 1'b1);
    chk64("midrst_read_old", rv_data, init_val(32'h20));

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
